hhmmss_timekeeper: RTL and testbench
====================================

Name: hhmmss_timekeeper

Overview:
Synchronous BCD time-of-day counter: HH:MM:SS, up or down, 24h or 12h display. Successor to the minute/hour clock.
- Single clock domain; no ripple-clocked digit stages. All digits advance on one `clk` edge, gated by a prescaler tick.
- Adds seconds, a parametrised prescaler, run/pause, validated parallel time load, 12h/AM-PM display, and a day-wrap pulse.
- Sits between the board clock and the 7-segment display mux.

Parameters:
- CLK_DIV, 1_000_000, `clk` cycles per one-second tick; legal range 1..2^24-1. A value of 1 ticks every cycle.
- DIV_W, $clog2(CLK_DIV+1), prescaler width. Derived; do not override.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  1 = count; 0 = hold time and prescaler.
- dec  in  1  1 = count down; 0 = count up. Sampled on each tick.
- mode_12h  in  1  display format select; display only.
- load  in  1  single-cycle request to load set_* values.
- set_h_tens, set_h_ones, set_m_tens, set_m_ones, set_s_tens, set_s_ones  in  4 each  BCD load value, always 24h format.
- sec_ones, sec_tens, min_ones, min_tens  out  4 each  BCD digits.
- hour_ones, hour_tens  out  4 each  BCD hour in the selected display format.
- pm  out  1  1 when internal hour ≥ 12. Valid in both modes.
- tick  out  1  one-cycle pulse on each counted second.
- day_carry  out  1  one-cycle pulse on 23:59:59→00:00:00 (up) or 00:00:00→23:59:59 (down).
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (async, active-high): all digits 0 (00:00:00); prescaler 0; tick, day_carry, load_err = 0; pm = 0. In 12h mode the hour digits read 12.
- Prescaler:
  - Counts 0..CLK_DIV-1 while run=1; holds while run=0.
  - When it equals CLK_DIV-1 with run=1, it wraps to 0 and tick is high for that same cycle.
  - The time registers update on the edge that ends the tick cycle. First tick after reset lands at cycle CLK_DIV.
- Internal state: 24h BCD (hour 00..23, min 00..59, sec 00..59).
- Carry/borrow chain is combinational within one cycle; all digits update on the same edge.
- Up count, per tick:
  - sec_ones 9→0 carries into sec_tens.
  - sec_tens 5→0 carries into min.
  - Minutes roll the same way as seconds; minute rollover carries into the hour.
  - Hour 23→00 asserts day_carry, coincident with tick.
- Down count:
  - Mirror of up count with borrows: 0→9 and 0→5 for the seconds/minutes digits.
  - Hour 00→23 asserts day_carry.
- Changing dec or run takes effect from the next tick; no partial-step glitch.
- Load:
  - Sampled at the edge where load=1.
  - Valid when every digit ≤ 9, s_tens ≤ 5, m_tens ≤ 5, and hour ≤ 23 (h_tens ≤ 2; h_tens = 2 requires h_ones ≤ 3).
  - Valid load: time registers take set_* on that edge and the prescaler clears to 0.
  - Invalid load: registers unchanged; load_err pulses high for the following cycle.
  - Load overrides a coincident tick: that tick is dropped, and neither tick nor day_carry pulses for it.
- 12h display (combinational from state; zero latency):
  - Internal hour 0 → 12.
  - Internal hours 1..12 → unchanged.
  - Internal hours 13..23 → hour−12, as BCD.
  - pm = (internal hour ≥ 12).
- 24h display: hour digits equal the internal hour.
- Outputs are glitch-free registered state, except the hour digits in 12h mode, which are a registered-state decode.
- Reset asserted mid-count: immediate return to reset values. No tick or day_carry fires on deassertion.

Optional Feature:
- Macro: HHMMSS_ALARM_EN.
- Defined: adds ports
  - alarm_set (in, 1)
  - alarm_h_tens, alarm_h_ones, alarm_m_tens, alarm_m_ones (in, 4 each)
  - alarm_arm (in, 1)
  - alarm_ack (in, 1)
  - alarm (out, 1)
- Alarm register: loaded when alarm_set=1, using the same validation as load without seconds. An invalid value is ignored and pulses load_err.
- alarm behaviour:
  - Sets when alarm_arm=1 and time reaches HH:MM:00 on a tick in either count direction.
  - Stays high until alarm_ack, or until alarm_arm=0.
  - If ack and a match occur in the same cycle, the match wins.
- Alarm register resets to 00:00.
- Not defined: none of these ports or registers exist; behaviour is otherwise identical.

Test Plan:
- CLK_DIV=4, reset then run=1 → first tick at cycle 4; sec_ones=1 after that edge; tick pulses every 4 cycles.
- Load 23:59:58, dec=0 → after 2 ticks, 00:00:00; day_carry high exactly on the second tick cycle; pm goes 1→0.
- Load 00:00:01, dec=1 → 00:00:00, then 23:59:59 with day_carry pulse; the next tick gives 23:59:58.
- Loads of 24:00:00, 12:60:00 and 09:5A:00 → each rejected: load_err pulses once, time unchanged. Load 13:07:00 accepted, with load coincident with tick → 13:07:00 held and no tick increment; mode_12h=1 shows 01:07 with pm=1. Internal 00:xx in mode_12h=1 shows 12, pm=0.
- run=0 for 10 cycles mid-second → prescaler frozen; time resumes with the remaining count. Async reset pulse between edges → all outputs 0 immediately.
- HHMMSS_ALARM_EN: alarm 07:30, armed, load 07:29:59 → alarm rises on the next tick; held until alarm_ack; not re-raised until the next 07:30:00 match.

Source files
------------

// File: rtl/hhmmss_timekeeper.sv
// Synchronous BCD HH:MM:SS time-of-day counter with prescaler, up/down count, validated load,
// 12h display decode and day-wrap pulse. Optional alarm enabled by defining HHMMSS_ALARM_EN.
module hhmmss_timekeeper #(
  parameter int unsigned CLK_DIV = 1_000_000,
  parameter int unsigned DIV_W   = $clog2(CLK_DIV + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       dec,
  input  logic       mode_12h,
  input  logic       load,
  input  logic [3:0] set_h_tens,
  input  logic [3:0] set_h_ones,
  input  logic [3:0] set_m_tens,
  input  logic [3:0] set_m_ones,
  input  logic [3:0] set_s_tens,
  input  logic [3:0] set_s_ones,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] hour_ones,
  output logic [3:0] hour_tens,
  output logic       pm,
  output logic       tick,
  output logic       day_carry,
  output logic       load_err
`ifdef HHMMSS_ALARM_EN
  ,
  input  logic       alarm_set,
  input  logic [3:0] alarm_h_tens,
  input  logic [3:0] alarm_h_ones,
  input  logic [3:0] alarm_m_tens,
  input  logic [3:0] alarm_m_ones,
  input  logic       alarm_arm,
  input  logic       alarm_ack,
  output logic       alarm
`endif
);

  localparam logic [DIV_W-1:0] DivMax = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;

  logic [3:0] s1_q, s10_q, m1_q, m10_q, h1_q, h10_q;
  logic [3:0] s1_d, s10_d, m1_d, m10_d, h1_d, h10_d;
  logic [3:0] s1_n, s10_n, m1_n, m10_n, h1_n, h10_n;

  logic load_err_q, load_err_d;
  logic tick_raw, load_ok, load_take, at_max, at_zero;

  // ---------------------------------------------------------------------------------------------
  // Prescaler and load qualification
  // ---------------------------------------------------------------------------------------------
  assign tick_raw = run && (div_q == DivMax);

  assign load_ok = (set_s_ones <= 4'd9) && (set_s_tens <= 4'd5) &&
                   (set_m_ones <= 4'd9) && (set_m_tens <= 4'd5) &&
                   (set_h_ones <= 4'd9) &&
                   ((set_h_tens <= 4'd1) || ((set_h_tens == 4'd2) && (set_h_ones <= 4'd3)));

  // A rejected load leaves counting untouched; only an accepted one swallows the tick.
  assign load_take = load && load_ok;
  assign tick      = tick_raw && !load_take;

  always_comb begin
    div_d = div_q;
    if (load_take) begin
      div_d = '0;
    end else if (run) begin
      div_d = tick_raw ? '0 : div_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // One-step successor/predecessor of the current time
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    s1_n  = s1_q;
    s10_n = s10_q;
    m1_n  = m1_q;
    m10_n = m10_q;
    h1_n  = h1_q;
    h10_n = h10_q;
    if (!dec) begin
      s1_n = (s1_q == 4'd9) ? 4'd0 : s1_q + 4'd1;
      if (s1_q == 4'd9) begin
        s10_n = (s10_q == 4'd5) ? 4'd0 : s10_q + 4'd1;
        if (s10_q == 4'd5) begin
          m1_n = (m1_q == 4'd9) ? 4'd0 : m1_q + 4'd1;
          if (m1_q == 4'd9) begin
            m10_n = (m10_q == 4'd5) ? 4'd0 : m10_q + 4'd1;
            if (m10_q == 4'd5) begin
              if ((h10_q == 4'd2) && (h1_q == 4'd3)) begin
                h10_n = 4'd0;
                h1_n  = 4'd0;
              end else if (h1_q == 4'd9) begin
                h10_n = h10_q + 4'd1;
                h1_n  = 4'd0;
              end else begin
                h1_n = h1_q + 4'd1;
              end
            end
          end
        end
      end
    end else begin
      s1_n = (s1_q == 4'd0) ? 4'd9 : s1_q - 4'd1;
      if (s1_q == 4'd0) begin
        s10_n = (s10_q == 4'd0) ? 4'd5 : s10_q - 4'd1;
        if (s10_q == 4'd0) begin
          m1_n = (m1_q == 4'd0) ? 4'd9 : m1_q - 4'd1;
          if (m1_q == 4'd0) begin
            m10_n = (m10_q == 4'd0) ? 4'd5 : m10_q - 4'd1;
            if (m10_q == 4'd0) begin
              if ((h10_q == 4'd0) && (h1_q == 4'd0)) begin
                h10_n = 4'd2;
                h1_n  = 4'd3;
              end else if (h1_q == 4'd0) begin
                h10_n = h10_q - 4'd1;
                h1_n  = 4'd9;
              end else begin
                h1_n = h1_q - 4'd1;
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    s1_d  = s1_q;
    s10_d = s10_q;
    m1_d  = m1_q;
    m10_d = m10_q;
    h1_d  = h1_q;
    h10_d = h10_q;
    if (load_take) begin
      s1_d  = set_s_ones;
      s10_d = set_s_tens;
      m1_d  = set_m_ones;
      m10_d = set_m_tens;
      h1_d  = set_h_ones;
      h10_d = set_h_tens;
    end else if (tick) begin
      s1_d  = s1_n;
      s10_d = s10_n;
      m1_d  = m1_n;
      m10_d = m10_n;
      h1_d  = h1_n;
      h10_d = h10_n;
    end
  end

  assign at_max  = (h10_q == 4'd2) && (h1_q == 4'd3) && (m10_q == 4'd5) && (m1_q == 4'd9) &&
                   (s10_q == 4'd5) && (s1_q == 4'd9);
  assign at_zero = (h10_q == 4'd0) && (h1_q == 4'd0) && (m10_q == 4'd0) && (m1_q == 4'd0) &&
                   (s10_q == 4'd0) && (s1_q == 4'd0);
  assign day_carry = tick && (dec ? at_zero : at_max);

  // ---------------------------------------------------------------------------------------------
  // Optional alarm
  // ---------------------------------------------------------------------------------------------
`ifdef HHMMSS_ALARM_EN
  logic [3:0] al_h10_q, al_h1_q, al_m10_q, al_m1_q;
  logic       alarm_q, alarm_d, alarm_ok, alarm_match;

  assign alarm_ok = (alarm_m_ones <= 4'd9) && (alarm_m_tens <= 4'd5) && (alarm_h_ones <= 4'd9) &&
                    ((alarm_h_tens <= 4'd1) ||
                     ((alarm_h_tens == 4'd2) && (alarm_h_ones <= 4'd3)));

  // Match on the value the counter is about to enter, so it fires on the tick that reaches it.
  assign alarm_match = tick && (s1_n == 4'd0) && (s10_n == 4'd0) &&
                       (m1_n == al_m1_q) && (m10_n == al_m10_q) &&
                       (h1_n == al_h1_q) && (h10_n == al_h10_q);

  always_comb begin
    alarm_d = alarm_q;
    if (!alarm_arm) begin
      alarm_d = 1'b0;
    end else if (alarm_match) begin
      alarm_d = 1'b1;
    end else if (alarm_ack) begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      al_h10_q <= 4'd0;
      al_h1_q  <= 4'd0;
      al_m10_q <= 4'd0;
      al_m1_q  <= 4'd0;
      alarm_q  <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
      if (alarm_set && alarm_ok) begin
        al_h10_q <= alarm_h_tens;
        al_h1_q  <= alarm_h_ones;
        al_m10_q <= alarm_m_tens;
        al_m1_q  <= alarm_m_ones;
      end
    end
  end

  assign alarm      = alarm_q;
  assign load_err_d = (load && !load_ok) || (alarm_set && !alarm_ok);
`else
  assign load_err_d = load && !load_ok;
`endif

  // ---------------------------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      s1_q       <= 4'd0;
      s10_q      <= 4'd0;
      m1_q       <= 4'd0;
      m10_q      <= 4'd0;
      h1_q       <= 4'd0;
      h10_q      <= 4'd0;
      load_err_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      s1_q       <= s1_d;
      s10_q      <= s10_d;
      m1_q       <= m1_d;
      m10_q      <= m10_d;
      h1_q       <= h1_d;
      h10_q      <= h10_d;
      load_err_q <= load_err_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Display outputs
  // ---------------------------------------------------------------------------------------------
  assign sec_ones = s1_q;
  assign sec_tens = s10_q;
  assign min_ones = m1_q;
  assign min_tens = m10_q;
  assign load_err = load_err_q;
  assign pm       = (h10_q == 4'd2) || ((h10_q == 4'd1) && (h1_q >= 4'd2));

  always_comb begin
    hour_tens = h10_q;
    hour_ones = h1_q;
    if (mode_12h) begin
      if ((h10_q == 4'd0) && (h1_q == 4'd0)) begin
        hour_tens = 4'd1;
        hour_ones = 4'd2;
      end else if ((h10_q == 4'd1) && (h1_q >= 4'd3)) begin
        hour_tens = 4'd0;
        hour_ones = h1_q - 4'd2;
      end else if ((h10_q == 4'd2) && (h1_q <= 4'd1)) begin
        hour_tens = 4'd0;
        hour_ones = h1_q + 4'd8;
      end else if (h10_q == 4'd2) begin
        hour_tens = 4'd1;
        hour_ones = h1_q - 4'd2;
      end
    end
  end

endmodule

// File: tb/tb_hhmmss_timekeeper.sv
// Directed self-checking bench for hhmmss_timekeeper with CLK_DIV=4.
module tb_hhmmss_timekeeper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0, dec = 1'b0, mode_12h = 1'b0, load = 1'b0;
  logic [3:0] set_h_tens = 4'd0, set_h_ones = 4'd0, set_m_tens = 4'd0;
  logic [3:0] set_m_ones = 4'd0, set_s_tens = 4'd0, set_s_ones = 4'd0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens;
  logic       pm, tick, day_carry, load_err;
`ifdef HHMMSS_ALARM_EN
  logic       alarm_set = 1'b0, alarm_arm = 1'b0, alarm_ack = 1'b0, alarm;
  logic [3:0] alarm_h_tens = 4'd0, alarm_h_ones = 4'd0, alarm_m_tens = 4'd0, alarm_m_ones = 4'd0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] cur_time;
  assign cur_time = {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones};

  always #5 clk = ~clk;

  hhmmss_timekeeper #(.CLK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .dec        (dec),
    .mode_12h   (mode_12h),
    .load       (load),
    .set_h_tens (set_h_tens),
    .set_h_ones (set_h_ones),
    .set_m_tens (set_m_tens),
    .set_m_ones (set_m_ones),
    .set_s_tens (set_s_tens),
    .set_s_ones (set_s_ones),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .min_tens   (min_tens),
    .hour_ones  (hour_ones),
    .hour_tens  (hour_tens),
    .pm         (pm),
    .tick       (tick),
    .day_carry  (day_carry),
    .load_err   (load_err)
`ifdef HHMMSS_ALARM_EN
    ,
    .alarm_set    (alarm_set),
    .alarm_h_tens (alarm_h_tens),
    .alarm_h_ones (alarm_h_ones),
    .alarm_m_tens (alarm_m_tens),
    .alarm_m_ones (alarm_m_ones),
    .alarm_arm    (alarm_arm),
    .alarm_ack    (alarm_ack),
    .alarm        (alarm)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < 12) begin
      if (tick === 1'b1) ok = 1'b1;
      else begin
        cyc();
        n++;
      end
    end
  endtask

  task automatic do_load(input logic [23:0] t);
    {set_h_tens, set_h_ones, set_m_tens, set_m_ones, set_s_tens, set_s_ones} = t;
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if (cur_time !== 24'h000000) begin
      n_err++; $display("FAIL reset_time: got %h want 000000", cur_time);
    end
    n_cmp++;
    if ({pm, tick, day_carry, load_err} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b want 0000", {pm, tick, day_carry, load_err});
    end
    mode_12h = 1'b1;
    #1;
    n_cmp++;
    if ({hour_tens, hour_ones} !== 8'h12) begin
      n_err++; $display("FAIL reset_12h: got %h want 12", {hour_tens, hour_ones});
    end
    mode_12h = 1'b0;
  endtask

  task automatic test_prescaler();
    @(posedge clk);
    #1;
    reset = 1'b0;
    run   = 1'b1;
    for (int c = 0; c < 8; c++) begin
      n_cmp++;
      if (tick !== ((c % 4) == 3)) begin
        n_err++; $display("FAIL presc_tick c=%0d: got %b want %b", c, tick, (c % 4) == 3);
      end
      n_cmp++;
      if (sec_ones !== 4'(c / 4)) begin
        n_err++; $display("FAIL presc_sec c=%0d: got %0d want %0d", c, sec_ones, c / 4);
      end
      cyc();
    end
    n_cmp++;
    if (cur_time !== 24'h000002) begin
      n_err++; $display("FAIL presc_end: got %h want 000002", cur_time);
    end
    run = 1'b0;
  endtask

  task automatic test_wrap_up();
    bit ok;
    dec = 1'b0;
    do_load(24'h235958);
    n_cmp++;
    if ({cur_time, pm} !== {24'h235958, 1'b1}) begin
      n_err++; $display("FAIL up_load: got %h pm=%b want 235958 pm=1", cur_time, pm);
    end
    run = 1'b1;
    wait_tick(ok);
    n_cmp++;
    if ({ok, day_carry} !== 2'b10) begin
      n_err++; $display("FAIL up_tick1: got ok=%b dc=%b want ok=1 dc=0", ok, day_carry);
    end
    cyc();
    n_cmp++;
    if (cur_time !== 24'h235959) begin
      n_err++; $display("FAIL up_step1: got %h want 235959", cur_time);
    end
    wait_tick(ok);
    n_cmp++;
    if ({ok, day_carry, pm} !== 3'b111) begin
      n_err++; $display("FAIL up_tick2: got ok/dc/pm=%b want 111", {ok, day_carry, pm});
    end
    cyc();
    n_cmp++;
    if ({cur_time, pm, day_carry} !== {24'h000000, 2'b00}) begin
      n_err++; $display("FAIL up_wrap: got %h pm=%b dc=%b want 000000 0 0", cur_time, pm,
                        day_carry);
    end
    run = 1'b0;
  endtask

  task automatic test_wrap_down();
    bit ok;
    dec = 1'b1;
    do_load(24'h000001);
    run = 1'b1;
    wait_tick(ok);
    n_cmp++;
    if ({ok, day_carry} !== 2'b10) begin
      n_err++; $display("FAIL dn_tick1: got ok=%b dc=%b want 1 0", ok, day_carry);
    end
    cyc();
    n_cmp++;
    if (cur_time !== 24'h000000) begin
      n_err++; $display("FAIL dn_step1: got %h want 000000", cur_time);
    end
    wait_tick(ok);
    n_cmp++;
    if ({ok, day_carry} !== 2'b11) begin
      n_err++; $display("FAIL dn_tick2: got ok=%b dc=%b want 1 1", ok, day_carry);
    end
    cyc();
    n_cmp++;
    if ({cur_time, pm} !== {24'h235959, 1'b1}) begin
      n_err++; $display("FAIL dn_wrap: got %h pm=%b want 235959 1", cur_time, pm);
    end
    wait_tick(ok);
    n_cmp++;
    if ({ok, day_carry} !== 2'b10) begin
      n_err++; $display("FAIL dn_tick3: got ok=%b dc=%b want 1 0", ok, day_carry);
    end
    cyc();
    n_cmp++;
    if (cur_time !== 24'h235958) begin
      n_err++; $display("FAIL dn_step3: got %h want 235958", cur_time);
    end
    run = 1'b0;
    dec = 1'b0;
  endtask

  task automatic test_load_reject();
    logic [23:0] bad [3];
    bad[0] = 24'h240000;
    bad[1] = 24'h126000;
    bad[2] = 24'h095A00;
    for (int i = 0; i < 3; i++) begin
      do_load(bad[i]);
      n_cmp++;
      if ({load_err, cur_time} !== {1'b1, 24'h235958}) begin
        n_err++; $display("FAIL rej%0d: got err=%b t=%h want 1 235958", i, load_err, cur_time);
      end
      cyc();
      n_cmp++;
      if (load_err !== 1'b0) begin
        n_err++; $display("FAIL rej%0d_once: got err=%b want 0", i, load_err);
      end
    end
  endtask

  task automatic test_load_tick();
    bit ok;
    logic [7:0] hrs [6];
    logic [8:0] disp [6];
    run = 1'b1;
    wait_tick(ok);
    {set_h_tens, set_h_ones, set_m_tens, set_m_ones, set_s_tens, set_s_ones} = 24'h130700;
    load = 1'b1;
    #1;
    n_cmp++;
    if ({ok, tick, day_carry} !== 3'b100) begin
      n_err++; $display("FAIL ldtick_drop: got ok/tick/dc=%b want 100", {ok, tick, day_carry});
    end
    cyc();
    load = 1'b0;
    n_cmp++;
    if ({cur_time, load_err} !== {24'h130700, 1'b0}) begin
      n_err++; $display("FAIL ldtick_val: got %h err=%b want 130700 0", cur_time, load_err);
    end
    cyc(); cyc(); cyc();
    n_cmp++;
    if (tick !== 1'b1) begin
      n_err++; $display("FAIL ldtick_presc: got tick=%b want 1", tick);
    end
    run = 1'b0;
    mode_12h = 1'b1;
    #1;
    n_cmp++;
    if ({hour_tens, hour_ones, min_tens, min_ones, pm} !== {16'h0107, 1'b1}) begin
      n_err++; $display("FAIL h12_13: got %h%h:%h%h pm=%b want 01:07 1", hour_tens, hour_ones,
                        min_tens, min_ones, pm);
    end
    hrs[0] = 8'h00; disp[0] = {8'h12, 1'b0};
    hrs[1] = 8'h12; disp[1] = {8'h12, 1'b1};
    hrs[2] = 8'h23; disp[2] = {8'h11, 1'b1};
    hrs[3] = 8'h10; disp[3] = {8'h10, 1'b0};
    hrs[4] = 8'h19; disp[4] = {8'h07, 1'b1};
    hrs[5] = 8'h20; disp[5] = {8'h08, 1'b1};
    for (int i = 0; i < 6; i++) begin
      do_load({hrs[i], 16'h3000});
      n_cmp++;
      if ({hour_tens, hour_ones, pm} !== disp[i]) begin
        n_err++; $display("FAIL h12_%h: got %h%h pm=%b want %h", hrs[i], hour_tens, hour_ones,
                          pm, disp[i]);
      end
    end
    mode_12h = 1'b0;
  endtask

  task automatic test_pause();
    do_load(24'h100000);
    run = 1'b1;
    cyc(); cyc();
    run = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    n_cmp++;
    if (cur_time !== 24'h100000) begin
      n_err++; $display("FAIL pause_hold: got %h want 100000", cur_time);
    end
    run = 1'b1;
    #1;
    n_cmp++;
    if (tick !== 1'b0) begin
      n_err++; $display("FAIL pause_resume0: got tick=%b want 0", tick);
    end
    cyc();
    n_cmp++;
    if (tick !== 1'b1) begin
      n_err++; $display("FAIL pause_resume1: got tick=%b want 1", tick);
    end
    cyc();
    n_cmp++;
    if (cur_time !== 24'h100001) begin
      n_err++; $display("FAIL pause_step: got %h want 100001", cur_time);
    end
    run = 1'b0;
  endtask

  task automatic test_async_reset();
    do_load(24'h154530);
    run = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({cur_time, pm, tick, day_carry, load_err} !== 28'h0) begin
      n_err++; $display("FAIL areset: got %h flags=%b want 000000 0000", cur_time,
                        {pm, tick, day_carry, load_err});
    end
    cyc(); cyc();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if ({tick, day_carry} !== {c == 3, 1'b0}) begin
        n_err++; $display("FAIL areset_rel c=%0d: got %b want %b", c, {tick, day_carry},
                          {c == 3, 1'b0});
      end
      cyc();
    end
    run = 1'b0;
  endtask

`ifdef HHMMSS_ALARM_EN
  task automatic test_alarm();
    bit ok;
    {alarm_h_tens, alarm_h_ones, alarm_m_tens, alarm_m_ones} = 16'h2500;
    alarm_set = 1'b1;
    cyc();
    alarm_set = 1'b0;
    n_cmp++;
    if (load_err !== 1'b1) begin
      n_err++; $display("FAIL al_bad: got err=%b want 1", load_err);
    end
    {alarm_h_tens, alarm_h_ones, alarm_m_tens, alarm_m_ones} = 16'h0730;
    alarm_set = 1'b1;
    cyc();
    alarm_set = 1'b0;
    alarm_arm = 1'b1;
    do_load(24'h072959);
    n_cmp++;
    if (alarm !== 1'b0) begin
      n_err++; $display("FAIL al_idle: got %b want 0", alarm);
    end
    run = 1'b1;
    wait_tick(ok);
    cyc();
    run = 1'b0;
    n_cmp++;
    if ({ok, alarm, cur_time} !== {2'b11, 24'h073000}) begin
      n_err++; $display("FAIL al_rise: got ok=%b al=%b t=%h want 1 1 073000", ok, alarm,
                        cur_time);
    end
    cyc(); cyc();
    n_cmp++;
    if (alarm !== 1'b1) begin
      n_err++; $display("FAIL al_hold: got %b want 1", alarm);
    end
    alarm_ack = 1'b1;
    cyc();
    alarm_ack = 1'b0;
    n_cmp++;
    if (alarm !== 1'b0) begin
      n_err++; $display("FAIL al_ack: got %b want 0", alarm);
    end
    run = 1'b1;
    wait_tick(ok);
    cyc();
    run = 1'b0;
    n_cmp++;
    if ({ok, alarm} !== 2'b10) begin
      n_err++; $display("FAIL al_norearm: got ok=%b al=%b want 1 0", ok, alarm);
    end
    alarm_arm = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_prescaler();
    test_wrap_up();
    test_wrap_down();
    test_load_reject();
    test_load_tick();
    test_pause();
    test_async_reset();
`ifdef HHMMSS_ALARM_EN
    test_alarm();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
